bnn_weight_streamer: RTL and testbench

Host-side transmitter for the BNN weight-load bus. It holds a local image of one NUM_WEIGHTS-bit weight word per neuron. On a start command it drives exactly NUM_NEURONS load beats (load_en plus weight word) in neuron order 0..NUM_NEURONS-1, with a programmable idle gap between beats. Its outputs connect directly to the BNN core's load_en and weight bidir pins, and every beat advances the core's internal load pointer by one.

---
 rtl/bnn_weight_streamer_if.sv | 29 ++
 rtl/bnn_weight_streamer.sv | 125 ++++++++++++
 tb/tb_bnn_weight_streamer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_weight_streamer_if.sv
// Command and weight-load bus between the host controller and the BNN weight streamer.
// The streamer takes the slave view; whoever issues writes/start/abort takes the master view.
interface bnn_weight_streamer_if #(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_WEIGHTS = 6
);
    localparam int ADDR_W = $clog2(NUM_NEURONS);

    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [NUM_WEIGHTS-1:0] wr_data;
    logic                   start;
    logic                   abort;
    logic                   load_en;
    logic [NUM_WEIGHTS-1:0] load_data;
    logic                   busy;
    logic                   done;
    logic                   aborted;

    modport master (
        output wr_en, wr_addr, wr_data, start, abort,
        input  load_en, load_data, busy, done, aborted
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, abort,
        output load_en, load_data, busy, done, aborted
    );
endinterface

// File: rtl/bnn_weight_streamer.sv
// Streams a locally held image of per-neuron weight words onto the BNN core's load bus,
// one beat per neuron in order, separated by a fixed idle gap.
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_WEIGHTS = 6,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bnn_weight_streamer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [3:0] GAP_RELOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, GAP, DONE, ABORT} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       next_idx;
    logic [3:0]             gap_cnt;
    logic [3:0]             next_gap;
    logic [NUM_WEIGHTS-1:0] image [NUM_NEURONS];
    logic [NUM_WEIGHTS-1:0] beat_word;
    logic                   addr_ok;
    logic                   wr_take;

    logic                   load_en_q;
    logic [NUM_WEIGHTS-1:0] load_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   aborted_q;

    assign addr_ok = int'(bus.wr_addr) < NUM_NEURONS;
    assign wr_take = (state == IDLE) && bus.wr_en && addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                image[i] <= '0;
            end
        end else if (wr_take) begin
            image[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_gap   = gap_cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = LOAD;
                    next_idx   = '0;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    next_state = ABORT;
                end else if (idx == LAST_IDX) begin
                    next_state = DONE;
                end else begin
                    next_idx = idx + 1'b1;
                    if (GAP_CYCLES == 0) begin
                        next_state = LOAD;
                    end else begin
                        next_state = GAP;
                        next_gap   = GAP_RELOAD;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    next_state = ABORT;
                end else if (gap_cnt == 4'd0) begin
                    next_state = LOAD;
                end else begin
                    next_gap = gap_cnt - 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so a write landing on the start edge
    // has to be forwarded into the first beat instead of read from the old image entry.
    always_comb begin
        beat_word = image[next_idx];
        if (wr_take && (bus.wr_addr == next_idx)) begin
            beat_word = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            gap_cnt     <= '0;
            load_en_q   <= 1'b0;
            load_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state       <= next_state;
            idx         <= next_idx;
            gap_cnt     <= next_gap;
            load_en_q   <= (next_state == LOAD);
            load_data_q <= (next_state == LOAD) ? beat_word : '0;
            busy_q      <= (next_state == LOAD) || (next_state == GAP);
            done_q      <= (next_state == DONE);
            aborted_q   <= (next_state == ABORT);
        end
    end

    assign bus.load_en   = load_en_q;
    assign bus.load_data = load_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Bench for bnn_weight_streamer: a cycle-offset reference model predicts every output cycle
// from the beat schedule; a second instance with no gap covers back-to-back streaming.
module tb_bnn_weight_streamer;
    localparam int N        = 4;
    localparam int W        = 6;
    localparam int G        = 1;
    localparam int AW       = $clog2(N);
    localparam int P        = G + 1;
    localparam int DONE_OFF = 1 + (N - 1) * P + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bnn_weight_streamer_if #(.NUM_NEURONS(N), .NUM_WEIGHTS(W)) bus ();
    bnn_weight_streamer_if #(.NUM_NEURONS(N), .NUM_WEIGHTS(W)) bus0 ();

    bnn_weight_streamer #(.NUM_NEURONS(N), .NUM_WEIGHTS(W), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bnn_weight_streamer #(.NUM_NEURONS(N), .NUM_WEIGHTS(W), .GAP_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: image contents plus the edge on which the current stream started.
    logic [W-1:0] m_img [N];
    bit           m_active;
    bit           m_hold;
    int           m_edge;
    int           m_s0;
    logic [W+3:0] m_exp;

    wire [W+3:0] obs  = {bus.load_en, bus.load_data, bus.busy, bus.done, bus.aborted};
    wire [W+3:0] obs0 = {bus0.load_en, bus0.load_data, bus0.busy, bus0.done, bus0.aborted};

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_img[i] = '0;
        m_active = 1'b0;
        m_hold   = 1'b0;
        m_edge   = 0;
        m_s0     = 0;
        m_exp    = '0;
    endtask

    // Predicts the outputs for the cycle that follows the current rising edge.
    task automatic model_edge();
        int nxt;
        m_exp = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_edge++;
        if (m_hold) begin
            m_hold = 1'b0;
        end else if (m_active) begin
            nxt = m_edge - m_s0 + 1;
            if (bus.abort) begin
                m_exp[0] = 1'b1;
                m_active = 1'b0;
                m_hold   = 1'b1;
            end else if (nxt == DONE_OFF) begin
                m_exp[1] = 1'b1;
                m_active = 1'b0;
                m_hold   = 1'b1;
            end else if ((nxt - 1) % P == 0) begin
                m_exp = {1'b1, m_img[(nxt - 1) / P], 1'b1, 2'b00};
            end else begin
                m_exp[2] = 1'b1;
            end
        end else begin
            if (bus.wr_en && int'(bus.wr_addr) < N) m_img[bus.wr_addr] = bus.wr_data;
            if (bus.start) begin
                m_active = 1'b1;
                m_s0     = m_edge;
                m_exp    = {1'b1, m_img[0], 1'b1, 2'b00};
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(bit we, logic [AW-1:0] a, logic [W-1:0] d, bit st, bit ab);
        bus.wr_en   = we;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.start   = st;
        bus.abort   = ab;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom_range(0, 1)), AW'($urandom), W'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, {(W+4){1'b0}});
            end
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0);
        for (int c = 0; c < 11; c++) begin
            tick();
            set_in(0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL reset_empty_stream cyc=%0d got=%b exp=%b", c, obs, m_exp);
            end
        end
    endtask

    task automatic test_normal_stream();
        logic [W-1:0] words [N];
        words[0] = 6'b111000;
        words[1] = 6'b000111;
        words[2] = 6'b001100;
        words[3] = 6'b110011;
        for (int i = 0; i < N; i++) begin
            set_in(1, AW'(i), words[i], 0, 0);
            tick();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL normal_write cyc=%0d got=%b exp=%b", i, obs, m_exp);
            end
        end
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            set_in(0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL normal_stream cyc=k+%0d got=%b exp=%b", c, obs, m_exp);
            end
        end
    endtask

    task automatic test_ignored_commands();
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) set_in(1, 0, 6'b111111, 1, 0);
            else set_in(0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL ignored_cmds cyc=k+%0d got=%b exp=%b", c, obs, m_exp);
            end
        end
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            set_in(0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL ignored_restream cyc=k+%0d got=%b exp=%b", c, obs, m_exp);
            end
            if (c == 1) begin
                n_tests++;
                if (bus.load_data !== 6'b111000) begin
                    n_fail++;
                    $display("[TB] FAIL ignored_entry0 got=%b exp=%b", bus.load_data, 6'b111000);
                end
            end
        end
    endtask

    task automatic test_abort();
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            set_in(0, 0, 0, 0, (c == 2));
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL abort_stream cyc=k+%0d got=%b exp=%b", c, obs, m_exp);
            end
            if (c == 3) begin
                n_tests++;
                if (obs !== {1'b0, 6'b000000, 1'b0, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("[TB] FAIL abort_pulse got=%b exp=%b", obs,
                             {1'b0, 6'b000000, 1'b0, 1'b0, 1'b1});
                end
            end
        end
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            set_in(0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL abort_restream cyc=k+%0d got=%b exp=%b", c, obs, m_exp);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom_range(0, 3) == 0), AW'($urandom), W'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
            tick();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL random cyc=%0d got=%b exp=%b", c, obs, m_exp);
            end
        end
        set_in(0, 0, 0, 0, 0);
        repeat (DONE_OFF + 2) tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] bw [N];
        logic [W+3:0] e;
        bw[0] = 6'b000001;
        bw[1] = 6'b000010;
        bw[2] = 6'b000100;
        bw[3] = 6'b101010;
        for (int i = 0; i < N - 1; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_addr = AW'(i);
            bus0.wr_data = bw[i];
            tick();
        end
        bus0.wr_addr = 2'd3;
        bus0.wr_data = 6'b101010;
        bus0.start   = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            bus0.wr_en = 1'b0;
            bus0.start = 1'b0;
            e = {(c <= N), (c <= N) ? bw[c-1] : 6'b000000, (c <= N), (c == N + 1), 1'b0};
            n_tests++;
            if (obs0 !== e) begin
                n_fail++;
                $display("[TB] FAIL back_to_back cyc=k+%0d got=%b exp=%b", c, obs0, e);
            end
        end
    endtask

    task automatic test_async_reset();
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            set_in(0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL async_pre cyc=k+%0d got=%b exp=%b", c, obs, m_exp);
            end
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_clear got=%b exp=%b", obs, {(W+4){1'b0}});
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        set_in(0, 0, 0, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            set_in(0, 0, 0, 0, 0);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("[TB] FAIL async_restream cyc=k+%0d got=%b exp=%b", c, obs, m_exp);
            end
            if (c == 1) begin
                n_tests++;
                if (bus.load_en !== 1'b1 || bus.load_data !== 6'b000000) begin
                    n_fail++;
                    $display("[TB] FAIL async_entry0 got en=%b data=%b exp en=1 data=000000",
                             bus.load_en, bus.load_data);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        bus0.wr_en   = 1'b0;
        bus0.wr_addr = '0;
        bus0.wr_data = '0;
        bus0.start   = 1'b0;
        bus0.abort   = 1'b0;
        model_reset();
        test_reset();
        test_normal_stream();
        test_ignored_commands();
        test_abort();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
